// File: rtl/point_add_pkg.sv
// Shared curve types, secp256k1 constants and modular add/sub helpers.
// Pure declarations and combinational functions; no clocked logic.
// No flow control; the helpers are single-cycle combinational.
package elliptic_curve_structs;

    localparam int P_WIDTH = 256;

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;

    // secp256k1 field modulus and curve constant (y^2 = x^3 + 7)
    localparam logic [P_WIDTH-1:0] PRIME =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [P_WIDTH-1:0] B = 256'd7;

    localparam curve_point_t G = '{
        x: 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798,
        y: 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8
    };

    typedef enum logic [2:0] {
        IDLE_START,
        SUB,
        INV,
        LAMBDA,
        X3,
        Y3,
        FIN
    } pa_state_t;

    // (a + b) mod m, operands already reduced
    function automatic logic [P_WIDTH-1:0] mod_add(input logic [P_WIDTH-1:0] a,
                                                   input logic [P_WIDTH-1:0] b,
                                                   input logic [P_WIDTH-1:0] m);
        logic [P_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[P_WIDTH-1:0];
    endfunction

    // (a - b) mod m, operands already reduced; borrow folds back by adding m
    function automatic logic [P_WIDTH-1:0] mod_sub(input logic [P_WIDTH-1:0] a,
                                                   input logic [P_WIDTH-1:0] b,
                                                   input logic [P_WIDTH-1:0] m);
        logic [P_WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[P_WIDTH])
            d = d + {1'b0, m};
        return d[P_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/point_add_mul.sv
// Modular multiplier p = a*b mod PRIME, MSB-first interleaved shift-add.
// Latency: start edge + NBITS step edges; done pulses for one cycle after.
// No backpressure: start is accepted whenever asserted and restarts the product.
module mod_mul
    import elliptic_curve_structs::*;
#(
    parameter logic [P_WIDTH-1:0] PRIME = elliptic_curve_structs::PRIME,
    parameter int unsigned        NBITS = P_WIDTH
)(
    input  logic               clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    output logic               done,
    output logic [P_WIDTH-1:0] p
);
    localparam int IW = $clog2(P_WIDTH);
    localparam logic [P_WIDTH+1:0] PX = {2'b00, PRIME};

    logic [P_WIDTH-1:0] a_r, b_r, acc;
    logic [P_WIDTH+1:0] step;
    logic [IW-1:0]      idx;
    logic               busy;

    assign p = acc;

    // One bit of the product: 2*acc + (b[i] ? a : 0) is below 3*PRIME, so two trims suffice
    always_comb begin
        step = {1'b0, acc, 1'b0} + (b_r[idx] ? {2'b00, a_r} : '0);
        if (step >= PX)
            step = step - PX;
        if (step >= PX)
            step = step - PX;
    end

    // Operand capture, bit walk and done pulse
    always_ff @(posedge clk) begin
        if (Reset) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r  <= a;
                b_r  <= b;
                acc  <= '0;
                idx  <= IW'(NBITS - 1);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= step[P_WIDTH-1:0];
                if (idx == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/point_add.sv
// Affine point adder R = P + Q on y^2 = x^3 + b over GF(PRIME).
// Latency: 2 + (2*NBITS+3)*(NBITS+2) cycles after Reset falls; 2 for degenerate inputs.
// No backpressure: Reset restarts; Done and R hold until the next Reset.
module point_add
    import elliptic_curve_structs::*;
#(
    parameter logic [P_WIDTH-1:0] PRIME = elliptic_curve_structs::PRIME,
    parameter int unsigned        NBITS = P_WIDTH
)(
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    input  curve_point_t Q,
    output logic         Done,
    output curve_point_t R
);
    localparam int IW = $clog2(P_WIDTH);
    localparam logic [P_WIDTH-1:0] EXP = PRIME - P_WIDTH'(2);

    pa_state_t          state, next_state;
    curve_point_t       op_p, op_q;
    logic [P_WIDTH-1:0] dx, dy, inv, sq, lam, x3;
    logic [IW-1:0]      bit_idx;
    logic               inv_sq, mul_pend;
    logic               mul_start, mul_done;
    logic [P_WIDTH-1:0] mul_a, mul_b, mul_p;
    logic               p_inf, q_inf, dx_zero;

    assign p_inf   = (op_p == '0);
    assign q_inf   = (op_q == '0);
    assign dx_zero = (op_q.x == op_p.x);

    mod_mul #(.PRIME(PRIME), .NBITS(NBITS)) u_mul (
        .clk   (clk),
        .Reset (Reset),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .done  (mul_done),
        .p     (mul_p)
    );

    // State register; any Reset edge returns to IDLE_START
    always_ff @(posedge clk) begin
        if (Reset)
            state <= IDLE_START;
        else
            state <= next_state;
    end

    // Next state plus multiplier issue: one product in flight, started when none is pending
    always_comb begin
        next_state = state;
        mul_start  = 1'b0;
        mul_a      = inv;
        mul_b      = inv;
        case (state)
            IDLE_START: next_state = SUB;
            SUB:        next_state = (p_inf || q_inf || dx_zero) ? FIN : INV;
            INV: begin
                mul_start = !mul_pend;
                if (!inv_sq) begin
                    mul_a = sq;
                    mul_b = dx;
                end
                if (mul_done && !inv_sq && bit_idx == '0)
                    next_state = LAMBDA;
            end
            LAMBDA: begin
                mul_start = !mul_pend;
                mul_a     = dy;
                mul_b     = inv;
                if (mul_done)
                    next_state = X3;
            end
            X3: begin
                mul_start = !mul_pend;
                mul_a     = lam;
                mul_b     = lam;
                if (mul_done)
                    next_state = Y3;
            end
            Y3: begin
                mul_start = !mul_pend;
                mul_a     = lam;
                mul_b     = mod_sub(op_p.x, x3, PRIME);
                if (mul_done)
                    next_state = FIN;
            end
            FIN:     next_state = FIN;
            default: next_state = IDLE_START;
        endcase
    end

    // Operand capture, intermediate values and result; R/Done written on entry to FIN
    always_ff @(posedge clk) begin
        if (Reset) begin
            op_p     <= P;
            op_q     <= Q;
            R        <= '0;
            Done     <= 1'b0;
            dx       <= '0;
            dy       <= '0;
            inv      <= P_WIDTH'(1);
            sq       <= '0;
            lam      <= '0;
            x3       <= '0;
            bit_idx  <= IW'(NBITS - 1);
            inv_sq   <= 1'b1;
            mul_pend <= 1'b0;
        end else begin
            if (mul_start)
                mul_pend <= 1'b1;
            else if (mul_done)
                mul_pend <= 1'b0;
            case (state)
                SUB: begin
                    dx <= mod_sub(op_q.x, op_p.x, PRIME);
                    dy <= mod_sub(op_q.y, op_p.y, PRIME);
                    if (p_inf) begin
                        R    <= op_q;
                        Done <= 1'b1;
                    end else if (q_inf) begin
                        R    <= op_p;
                        Done <= 1'b1;
                    end else if (dx_zero) begin
                        R    <= '0;
                        Done <= 1'b1;
                    end
                end
                INV: begin
                    if (mul_done) begin
                        if (inv_sq) begin
                            sq     <= mul_p;
                            inv_sq <= 1'b0;
                        end else begin
                            inv     <= EXP[bit_idx] ? mul_p : sq;
                            inv_sq  <= 1'b1;
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                LAMBDA: if (mul_done) lam <= mul_p;
                X3: if (mul_done) x3 <= mod_sub(mod_sub(mul_p, op_p.x, PRIME), op_q.x, PRIME);
                Y3: begin
                    if (mul_done) begin
                        R    <= '{x: x3, y: mod_sub(mul_p, op_p.y, PRIME)};
                        Done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_point_add.sv
// Bench for point_add over GF(17), y^2 = x^3 + 7, with a reduced bit walk.
// Latency: compared against the closed-form bound and across operations.
// No backpressure: stimulus is driven through Reset only.
module tb_point_add;
    import elliptic_curve_structs::*;

    localparam int CW    = 2 * P_WIDTH;
    localparam int M     = 17;
    localparam int NB    = 5;
    localparam int BOUND = (2 * NB + 4) * (NB + 2);

    logic         clk = 1'b0;
    logic         Reset;
    curve_point_t P, Q, R;
    logic         Done;

    int errors = 0;
    int checks = 0;
    int ref_lat = -1;
    int ptx[$];
    int pty[$];

    point_add #(.PRIME(P_WIDTH'(M)), .NBITS(NB)) dut (
        .clk   (clk),
        .Reset (Reset),
        .P     (P),
        .Q     (Q),
        .Done  (Done),
        .R     (R)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic curve_point_t mk(input int x, input int y);
        curve_point_t c;
        c.x = P_WIDTH'(x);
        c.y = P_WIDTH'(y);
        return c;
    endfunction

    function automatic int md(input int v);
        return ((v % M) + M) % M;
    endfunction

    function automatic int inv_m(input int a);
        for (int k = 1; k < M; k++)
            if (md(a * k) == 1) return k;
        return 0;
    endfunction

    // Textbook affine chord rule with point-at-infinity encoded as (0,0)
    function automatic curve_point_t ref_add(input int px, input int py, input int qx, input int qy);
        int l, x3, y3;
        if (px == 0 && py == 0) return mk(qx, qy);
        if (qx == 0 && qy == 0) return mk(px, py);
        if (px == qx) return mk(0, 0);
        l  = md(md(qy - py) * inv_m(md(qx - px)));
        x3 = md(l * l - px - qx);
        y3 = md(l * (px - x3) - py);
        return mk(x3, y3);
    endfunction

    task automatic start_op(input int px, input int py, input int qx, input int qy);
        @(negedge clk);
        Reset = 1'b1;
        P = mk(px, py);
        Q = mk(qx, qy);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({tag, "_done_low_after_reset"}, CW'(Done), CW'(0));
            if (Done === 1'b1) break;
            if (lat > BOUND + 10) begin
                chk({tag, "_timeout"}, CW'(lat), CW'(BOUND));
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input int px, input int py, input int qx, input int qy);
        int lat;
        start_op(px, py, qx, qy);
        wait_done(tag, lat);
        chk({tag, "_R"}, R, ref_add(px, py, qx, qy));
        if ((px == 0 && py == 0) || (qx == 0 && qy == 0) || px == qx) begin
            chk({tag, "_lat_special"}, CW'(lat), CW'(2));
        end else begin
            chk({tag, "_lat_bound"}, CW'(lat <= BOUND), CW'(1));
            if (ref_lat < 0) ref_lat = lat;
            else chk({tag, "_lat_const"}, CW'(lat), CW'(ref_lat));
        end
    endtask

    initial begin
        int lat, bad, i0, i1, mode;
        curve_point_t held;
        Reset = 1'b1;
        P = '0;
        Q = '0;
        for (int x = 0; x < M; x++)
            for (int y = 0; y < M; y++)
                if (md(y * y) == md(x * x * x + 7)) begin
                    ptx.push_back(x);
                    pty.push_back(y);
                end
        repeat (3) @(negedge clk);
        chk("reset_done", CW'(Done), CW'(0));
        chk("reset_R", R, CW'(0));

        // Chord add with known answer, then Done/R must stay put
        run_check("t1", 1, 5, 5, 8);
        chk("t1_known", R, mk(2, 7));
        held = R;
        bad  = 0;
        repeat (100) begin
            @(negedge clk);
            if (Done !== 1'b1 || R !== held) bad++;
        end
        chk("t1_hold", CW'(bad), CW'(0));

        run_check("t2_commute", 5, 8, 1, 5);
        chk("t2_known", R, mk(2, 7));
        run_check("t3_inverse_pair", 1, 5, 1, 12);
        run_check("t3b_p_inf", 0, 0, 2, 7);
        run_check("t3c_q_inf", 2, 7, 0, 0);

        // Abort part way through and restart on new operands
        start_op(1, 5, 5, 8);
        repeat (46) @(negedge clk);
        Reset = 1'b1;
        P = mk(2, 7);
        Q = mk(1, 5);
        @(negedge clk);
        chk("t4_done_low_in_reset", CW'(Done), CW'(0));
        Reset = 1'b0;
        wait_done("t4", lat);
        chk("t4_R", R, ref_add(2, 7, 1, 5));
        chk("t4_lat", CW'(lat), CW'(ref_lat));

        // Inputs wiggle after capture; result must come from captured operands
        start_op(1, 5, 5, 8);
        @(posedge clk);
        #1;
        P = mk(3, 0);
        Q = mk(2, 10);
        wait_done("t5", lat);
        chk("t5_R", R, mk(2, 7));

        // Multi-cycle Reset: only the last Reset-cycle operands count
        @(negedge clk);
        Reset = 1'b1;
        P = mk(3, 0);
        Q = mk(2, 10);
        @(negedge clk);
        P = mk(1, 5);
        Q = mk(5, 8);
        @(negedge clk);
        Reset = 1'b0;
        wait_done("t6", lat);
        chk("t6_R", R, mk(2, 7));

        for (int n = 0; n < 24; n++) begin
            i0   = $urandom_range(0, ptx.size() - 1);
            i1   = $urandom_range(0, ptx.size() - 1);
            mode = $urandom_range(0, 9);
            case (mode)
                0:       run_check("rnd_p_inf", 0, 0, ptx[i1], pty[i1]);
                1:       run_check("rnd_q_inf", ptx[i0], pty[i0], 0, 0);
                2:       run_check("rnd_neg", ptx[i0], pty[i0], ptx[i0], md(M - pty[i0]));
                3:       run_check("rnd_same", ptx[i0], pty[i0], ptx[i0], pty[i0]);
                default: run_check("rnd_add", ptx[i0], pty[i0], ptx[i1], pty[i1]);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
